// File: rtl/fp32_mul_sc.sv
// fp32_mul_sc: IEEE-754 binary32 multiplier with NaN/Inf/zero special cases,
// DAZ inputs, FTZ outputs, round-to-nearest-even, one registered output stage.
// Ports: clk, rst (sync, active-high), in_valid, a, b -> out_valid, z,
//        flags {invalid, overflow, underflow, inexact} when FP32_MUL_FLAGS_EN is defined.
module fp32_mul_sc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] z
`ifdef FP32_MUL_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Operand fields and classification
    logic        sa, sb, sz;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa = a[31];
    assign sb = b[31];
    assign ea = a[30:23];
    assign eb = b[30:23];
    assign fa = a[22:0];
    assign fb = b[22:0];
    assign sz = sa ^ sb;

    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    // exp=0 covers both true zero and subnormal (flushed to zero)
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    // Normal-path datapath
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_f;
    logic [23:0]       mant;
    logic              guard, sticky, rnd;
    logic [24:0]       mant_r;
    logic [22:0]       frac_f;
    logic              ovf, unf, inx;

    assign prod    = {1'b1, fa} * {1'b1, fb};
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    always_comb begin
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_sum + 10'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_sum;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, rnd};
        // Carry out of rounding leaves 1.000..0; shift and bump exponent
        if (mant_r[24]) begin
            frac_f = mant_r[23:1];
            exp_f  = exp_n + 10'sd1;
        end else begin
            frac_f = mant_r[22:0];
            exp_f  = exp_n;
        end
        ovf = (exp_f >= 10'sd255);
        unf = (exp_f <= 10'sd0);
        inx = guard | sticky;
    end

    // Result selection, highest priority first
    logic [31:0] res_z;

    always_comb begin
        if (a_nan || b_nan) begin
            res_z = QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            res_z = QNAN;
        end else if (a_inf || b_inf) begin
            res_z = {sz, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res_z = {sz, 31'd0};
        end else if (ovf) begin
            res_z = {sz, 8'hFF, 23'd0};
        end else if (unf) begin
            res_z = {sz, 31'd0};
        end else begin
            res_z = {sz, exp_f[7:0], frac_f};
        end
    end

    logic        out_valid_q, out_valid_d;
    logic [31:0] z_q, z_d;

    assign out_valid_d = in_valid;
    assign z_d         = in_valid ? res_z : z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            z_q         <= 32'h0000_0000;
        end else begin
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;

`ifdef FP32_MUL_FLAGS_EN
    logic       a_sub, b_sub, a_nz, b_nz, daz_unf;
    logic [3:0] res_f;
    logic [3:0] flags_q, flags_d;

    assign a_sub = a_zero && (fa != 23'd0);
    assign b_sub = b_zero && (fb != 23'd0);
    assign a_nz  = (a[30:0] != 31'd0);
    assign b_nz  = (b[30:0] != 31'd0);
    // A flushed subnormal times a nonzero finite value is a lost tiny product
    assign daz_unf = (a_sub | b_sub) & a_nz & b_nz;

    always_comb begin
        if (a_nan || b_nan) begin
            res_f = 4'b1000;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            res_f = 4'b1000;
        end else if (a_inf || b_inf) begin
            res_f = 4'b0000;
        end else if (a_zero || b_zero) begin
            res_f = {2'b00, daz_unf, daz_unf};
        end else if (ovf) begin
            res_f = 4'b0101;
        end else if (unf) begin
            res_f = 4'b0011;
        end else begin
            res_f = {3'b000, inx};
        end
    end

    assign flags_d = in_valid ? res_f : flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp32_mul_sc.sv
// tb_fp32_mul_sc: scoreboard bench for fp32_mul_sc with an arithmetic
// reference model, directed corner vectors and randomized operands.
module tb_fp32_mul_sc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] z;
`ifdef FP32_MUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Expected {flags, z}
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    fp32_mul_sc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .z         (z)
`ifdef FP32_MUL_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    // Reference model: exact integer product, rounded with remainder arithmetic
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e, k;
        longint      fx, fy, p, q, rem, half;
        logic        xnan, ynan, xinf, yinf, xz, yz, xsub, ysub, inex;
        logic [31:0] r;
        logic [3:0]  f;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = longint'(x[22:0]);
        fy = longint'(y[22:0]);
        xnan = (ex == 255) && (fx != 0);
        ynan = (ey == 255) && (fy != 0);
        xinf = (ex == 255) && (fx == 0);
        yinf = (ey == 255) && (fy == 0);
        xz   = (ex == 0);
        yz   = (ey == 0);
        xsub = xz && (fx != 0);
        ysub = yz && (fy != 0);
        if (xnan || ynan || (xinf && yz) || (yinf && xz)) begin
            r = 32'h7FC0_0000;
            f = 4'b1000;
        end else if (xinf || yinf) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b0000;
        end else if (xz || yz) begin
            r = {s, 31'd0};
            f = ((xsub || ysub) && (x[30:0] != 0) && (y[30:0] != 0)) ? 4'b0011 : 4'b0000;
        end else begin
            p = (fx + (64'd1 << 23)) * (fy + (64'd1 << 23));
            e = ex + ey - 127;
            k = (p >= (64'd1 << 47)) ? 24 : 23;
            if (k == 24) e = e + 1;
            q    = p >> k;
            rem  = p - (q << k);
            half = 64'd1 << (k - 1);
            inex = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q / 2;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f = 4'b0011;
            end else begin
                r = {s, e[7:0], q[22:0]};
                f = {3'b000, inex};
            end
        end
        return {f, r};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] specials[8];
        logic [31:0] v;
        int          c, e;
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'hFF80_0001, 32'h7F7F_FFFF, 32'h0080_0000};
        c = $urandom_range(0, 15);
        if (c == 0) begin
            v = specials[$urandom_range(0, 7)];
        end else if (c == 1) begin
            v = {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
        end else begin
            e = (c < 9) ? $urandom_range(1, 254) : $urandom_range(100, 154);
            v = {$urandom_range(0, 1) == 1, e[7:0], 23'($urandom())};
        end
        return v;
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y,
                         input logic has_exp, input logic [31:0] zexp);
        logic [35:0] m;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        m        = ref_mul(x, y);
        if (has_exp) m[31:0] = zexp;
        exp_q.push_back(m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst      = 1'b0;
            in_valid = 1'b0;
            a        = $urandom();
            b        = $urandom();
        end
    endtask

    // Monitor: decides validity from the sampled controls, pops on output
    logic [31:0] hold_z = 32'h0;
    logic [3:0]  hold_f = 4'h0;

    initial begin
        logic        r, v;
        logic [35:0] m;
        forever begin
            @(posedge clk);
            r = rst;
            v = in_valid;
            #1;
            n_vec++;
            if (out_valid !== (!r && v)) begin
                n_err++;
                $display("FAIL out_valid: got %b want %b", out_valid, !r && v);
            end
            if (r) begin
                hold_z = 32'h0;
                hold_f = 4'h0;
                n_vec++;
                if (z !== 32'h0) begin
                    n_err++;
                    $display("FAIL reset_z: got %h want 00000000", z);
                end
`ifdef FP32_MUL_FLAGS_EN
                n_vec++;
                if (flags !== 4'h0) begin
                    n_err++;
                    $display("FAIL reset_flags: got %b want 0000", flags);
                end
`endif
            end else if (out_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_empty: got z=%h want no output", z);
                end else begin
                    m = exp_q.pop_front();
                    hold_z = m[31:0];
                    hold_f = m[35:32];
                    if (z !== m[31:0]) begin
                        n_err++;
                        $display("FAIL z: a=%h b=%h got %h want %h", a, b, z, m[31:0]);
                    end
`ifdef FP32_MUL_FLAGS_EN
                    n_vec++;
                    if (flags !== m[35:32]) begin
                        n_err++;
                        $display("FAIL flags: a=%h b=%h got %b want %b", a, b, flags, m[35:32]);
                    end
`endif
                end
            end else begin
                n_vec++;
                if (z !== hold_z) begin
                    n_err++;
                    $display("FAIL hold_z: got %h want %h", z, hold_z);
                end
`ifdef FP32_MUL_FLAGS_EN
                n_vec++;
                if (flags !== hold_f) begin
                    n_err++;
                    $display("FAIL hold_flags: got %b want %b", flags, hold_f);
                end
`endif
            end
        end
    end

    // Directed vectors with known products
    logic [95:0] dir_tab[] = '{
        {32'h3FC00000, 32'h40000000, 32'h40400000},
        {32'hC0200000, 32'h40800000, 32'hC1200000},
        {32'h3FC00000, 32'hC0000000, 32'hC0400000},
        {32'h00000000, 32'h40A00000, 32'h00000000},
        {32'h00000000, 32'h00000000, 32'h00000000},
        {32'h00000001, 32'h00800000, 32'h00000000},
        {32'h7FC00000, 32'h40400000, 32'h7FC00000},
        {32'h7FC00000, 32'h7F800000, 32'h7FC00000},
        {32'h7FC00000, 32'h00000000, 32'h7FC00000},
        {32'h7F800000, 32'h40000000, 32'h7F800000},
        {32'hFF800000, 32'h40400000, 32'hFF800000},
        {32'h7F800000, 32'h7F800000, 32'h7F800000},
        {32'hFF800000, 32'hFF800000, 32'h7F800000},
        {32'h7F800000, 32'hFF800000, 32'hFF800000},
        {32'h7F800000, 32'h00000000, 32'h7FC00000},
        {32'hFF800000, 32'h00000000, 32'h7FC00000},
        {32'h00000000, 32'h7F800000, 32'h7FC00000},
        {32'h7F7FFFFF, 32'h40000000, 32'h7F800000},
        {32'h3F800001, 32'h3FC00000, 32'h3FC00002},
        {32'h3F800003, 32'h3FC00000, 32'h3FC00004},
        {32'h80000000, 32'h3F800000, 32'h80000000},
        {32'h00800000, 32'h3F000000, 32'h00000000}
    };

    initial begin
        logic [95:0] d;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        repeat (3) @(negedge clk);

        foreach (dir_tab[i]) begin
            d = dir_tab[i];
            drive(d[95:64], d[63:32], 1'b1, d[31:0]);
        end
        idle(3);

        for (int i = 0; i < 600; i++) begin
            drive(rand_op(), rand_op(), 1'b0, 32'h0);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end

        // Reset in the middle of a stream, with in_valid high
        drive(32'h40400000, 32'h40400000, 1'b1, 32'h41100000);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h40000000;
        b        = 32'h40000000;
        idle(2);

        for (int i = 0; i < 200; i++) begin
            drive(rand_op(), rand_op(), 1'b0, 32'h0);
        end
        idle(4);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
